// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared processor widths plus the write-port arbiter defaults and types.
// Stands in for params_proc.v so every arbiter file imports one source of truth.
package regfile_wr_arbiter_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int CTRL_WIDTH     = 8;

  localparam int ARB_FIFO_DEPTH   = 2;
  localparam int ARB_PTR_WIDTH    = 1;
  localparam int ARB_STARVE_LIMIT = 4;
  localparam int ARB_CNT_WIDTH    = 3;

  typedef logic signed [DATA_WIDTH-1:0] data_t;
  typedef logic [REG_ADDR_WIDTH-1:0]    addr_t;

  typedef struct packed {
    logic  valid;
    addr_t addr;
    data_t data;
  } fifo_entry_t;

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_A,
    GRANT_POP,
    GRANT_BYPASS
  } grant_e;

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Bus bundle between the pipeline/multi-cycle units and the register-file
// write arbiter; master drives requests, slave is the arbiter.
interface regfile_wr_arbiter_if
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int PTR_WIDTH = ARB_PTR_WIDTH
);

  logic               wb_en;
  addr_t              wb_addr;
  data_t              wb_data;
  logic               mc_valid;
  logic               mc_ready;
  addr_t              mc_addr;
  data_t              mc_data;
  logic               rf_we;
  addr_t              rf_addr;
  data_t              rf_data;
  logic               stall_req;
  logic [PTR_WIDTH:0] fifo_count;

  modport master (
    output wb_en, wb_addr, wb_data, mc_valid, mc_addr, mc_data,
    input  mc_ready, rf_we, rf_addr, rf_data, stall_req, fifo_count
  );

  modport slave (
    input  wb_en, wb_addr, wb_data, mc_valid, mc_addr, mc_data,
    output mc_ready, rf_we, rf_addr, rf_data, stall_req, fifo_count
  );

endinterface

// File: rtl/regfile_wr_arbiter_wb_fifo.sv
// Circular buffer of pending multi-cycle results with squash-by-address:
// entries overwritten by a newer pipeline write keep their slot but lose valid.
module regfile_wr_arbiter_wb_fifo
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int DEPTH     = ARB_FIFO_DEPTH,
  parameter int PTR_WIDTH = ARB_PTR_WIDTH
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               push,
  input  addr_t              push_addr,
  input  data_t              push_data,
  input  logic               pop,
  input  logic               squash_en,
  input  addr_t              squash_addr,
  output fifo_entry_t        head,
  output logic [PTR_WIDTH:0] count,
  output logic               full,
  output logic               empty
);

  fifo_entry_t          mem_q [DEPTH];
  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH:0]   count_q, count_d;
  logic                 push_valid;

  assign push_valid = !(squash_en && (push_addr == squash_addr));
  assign rd_ptr_d   = pop  ? rd_ptr_q + PTR_WIDTH'(1) : rd_ptr_q;
  assign wr_ptr_d   = push ? wr_ptr_q + PTR_WIDTH'(1) : wr_ptr_q;
  assign count_d    = count_q + (PTR_WIDTH+1)'(push) - (PTR_WIDTH+1)'(pop);

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i].valid <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (squash_en && (mem_q[i].addr == squash_addr)) begin
          mem_q[i].valid <= 1'b0;
        end
      end
      // The push slot is always free, so this never fights a squash of live data.
      if (push) begin
        mem_q[wr_ptr_q] <= '{valid: push_valid, addr: push_addr, data: push_data};
      end
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == (PTR_WIDTH+1)'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: pipeline writeback always wins, buffered
// multi-cycle results drain in idle slots, starvation raises a stall request.
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH   = ARB_FIFO_DEPTH,
  parameter int PTR_WIDTH    = ARB_PTR_WIDTH,
  parameter int STARVE_LIMIT = ARB_STARVE_LIMIT,
  parameter int CNT_WIDTH    = ARB_CNT_WIDTH
) (
  input logic                 clk_in,
  input logic                 RST,
  regfile_wr_arbiter_if.slave bus
);

  fifo_entry_t          head;
  logic [PTR_WIDTH:0]   fifo_count_w;
  logic [PTR_WIDTH:0]   count_next;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 xfer;
  logic                 push;
  logic                 pop;
  grant_e               grant;

  logic                 rf_we_q, rf_we_d;
  addr_t                rf_addr_q, rf_addr_d;
  data_t                rf_data_q, rf_data_d;
  logic [CNT_WIDTH-1:0] starve_q, starve_d;
  logic                 stall_q, stall_d;

  // Ready depends on registered occupancy only; a same-cycle pop does not help.
  assign bus.mc_ready = !fifo_full;
  assign xfer         = bus.mc_valid && !fifo_full;

  always_comb begin
    grant = GRANT_NONE;
    if (bus.wb_en) begin
      grant = GRANT_A;
    end else if (!fifo_empty) begin
      grant = GRANT_POP;
    end else if (xfer) begin
      grant = GRANT_BYPASS;
    end
  end

  assign pop  = (grant == GRANT_POP);
  assign push = xfer && (grant != GRANT_BYPASS);

  regfile_wr_arbiter_wb_fifo #(
    .DEPTH     (FIFO_DEPTH),
    .PTR_WIDTH (PTR_WIDTH)
  ) u_wb_fifo (
    .clk_in      (clk_in),
    .rst_n       (RST),
    .push        (push),
    .push_addr   (bus.mc_addr),
    .push_data   (bus.mc_data),
    .pop         (pop),
    .squash_en   (bus.wb_en),
    .squash_addr (bus.wb_addr),
    .head        (head),
    .count       (fifo_count_w),
    .full        (fifo_full),
    .empty       (fifo_empty)
  );

  always_comb begin
    rf_we_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    case (grant)
      GRANT_A: begin
        rf_we_d   = 1'b1;
        rf_addr_d = bus.wb_addr;
        rf_data_d = bus.wb_data;
      end
      GRANT_POP: begin
        if (head.valid) begin
          rf_we_d   = 1'b1;
          rf_addr_d = head.addr;
          rf_data_d = head.data;
        end
      end
      GRANT_BYPASS: begin
        rf_we_d   = 1'b1;
        rf_addr_d = bus.mc_addr;
        rf_data_d = bus.mc_data;
      end
      default: ;
    endcase
  end

  assign count_next = fifo_count_w + (PTR_WIDTH+1)'(push) - (PTR_WIDTH+1)'(pop);

  always_comb begin
    starve_d = starve_q;
    if (pop) begin
      starve_d = '0;
    end else if (!fifo_empty && bus.wb_en && (starve_q != CNT_WIDTH'(STARVE_LIMIT))) begin
      starve_d = starve_q + CNT_WIDTH'(1);
    end
  end

  // Stall stays up until the buffer is drained, dropping right after the last pop.
  assign stall_d = (count_next != '0) && (stall_q || (starve_d == CNT_WIDTH'(STARVE_LIMIT)));

  always_ff @(posedge clk_in) begin
    if (!RST) begin
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
      starve_q  <= '0;
      stall_q   <= 1'b0;
    end else begin
      rf_we_q   <= rf_we_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
      starve_q  <= starve_d;
      stall_q   <= stall_d;
    end
  end

  assign bus.rf_we      = rf_we_q;
  assign bus.rf_addr    = rf_addr_q;
  assign bus.rf_data    = rf_data_q;
  assign bus.stall_req  = stall_q;
  assign bus.fifo_count = fifo_count_w;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: reset, A-only, bypass, contention/stall,
// squash and reset mid-drain, each step checked against hand-computed values.
module tb_regfile_wr_arbiter;
  import regfile_wr_arbiter_pkg::*;

  logic clk_in;
  logic RST;
  int   n_cmp  = 0;
  int   n_fail = 0;

  regfile_wr_arbiter_if #(.PTR_WIDTH(ARB_PTR_WIDTH)) bus ();

  regfile_wr_arbiter dut (
    .clk_in (clk_in),
    .RST    (RST),
    .bus    (bus.slave)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk_rf(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] data);
    chk({tag, ".rf_we"}, 32'(bus.rf_we), 32'(we));
    chk({tag, ".rf_addr"}, 32'(bus.rf_addr), addr);
    chk({tag, ".rf_data"}, bus.rf_data, data);
    $display("%0t %s: we=%0d addr=%0d data=%0d stall=%0d count=%0d ready=%0d", $time, tag,
             bus.rf_we, bus.rf_addr, bus.rf_data, bus.stall_req, bus.fifo_count, bus.mc_ready);
  endtask

  initial begin
    RST          = 1'b0;
    bus.wb_en    = 1'b0;
    bus.wb_addr  = '0;
    bus.wb_data  = '0;
    bus.mc_valid = 1'b0;
    bus.mc_addr  = '0;
    bus.mc_data  = '0;

    // Reset then idle
    step();
    step();
    chk_rf("reset", 1'b0, 0, 0);
    chk("reset.stall", 32'(bus.stall_req), 0);
    chk("reset.count", 32'(bus.fifo_count), 0);
    RST = 1'b1;
    step();
    chk("idle.ready", 32'(bus.mc_ready), 1);
    chk("idle.rf_we", 32'(bus.rf_we), 0);

    // A only
    bus.wb_en = 1'b1; bus.wb_addr = 5'd4; bus.wb_data = 32'sd1712;
    step();
    chk_rf("a_only", 1'b1, 4, 1712);
    bus.wb_en = 1'b0;
    step();
    chk_rf("a_off_hold", 1'b0, 4, 1712);

    // B bypass
    bus.mc_valid = 1'b1; bus.mc_addr = 5'd7; bus.mc_data = 32'sd956;
    step();
    chk_rf("bypass", 1'b1, 7, 956);
    chk("bypass.count", 32'(bus.fifo_count), 0);
    bus.mc_valid = 1'b0;
    step();
    chk("bypass_done.rf_we", 32'(bus.rf_we), 0);

    // Contention and fill
    bus.wb_en = 1'b1; bus.wb_addr = 5'd1; bus.wb_data = 32'sd15;
    bus.mc_valid = 1'b1; bus.mc_addr = 5'd2; bus.mc_data = 32'sd27;
    step();
    chk_rf("cont1", 1'b1, 1, 15);
    chk("cont1.count", 32'(bus.fifo_count), 1);
    bus.mc_addr = 5'd3; bus.mc_data = 32'sd3562;
    step();
    bus.mc_valid = 1'b0;
    chk_rf("cont2", 1'b1, 1, 15);
    chk("cont2.count", 32'(bus.fifo_count), 2);
    chk("cont2.ready", 32'(bus.mc_ready), 0);
    chk("cont2.stall", 32'(bus.stall_req), 0);
    step();
    step();
    chk("blocked3.stall", 32'(bus.stall_req), 0);
    step();
    chk("blocked4.stall", 32'(bus.stall_req), 1);
    chk("blocked4.ready", 32'(bus.mc_ready), 0);
    bus.wb_en = 1'b0;
    step();
    chk_rf("drain1", 1'b1, 2, 27);
    chk("drain1.stall", 32'(bus.stall_req), 1);
    chk("drain1.count", 32'(bus.fifo_count), 1);
    step();
    chk_rf("drain2", 1'b1, 3, 3562);
    chk("drain2.stall", 32'(bus.stall_req), 0);
    chk("drain2.count", 32'(bus.fifo_count), 0);
    step();
    chk("drain_idle.rf_we", 32'(bus.rf_we), 0);

    // Squash of an older buffered entry
    bus.wb_en = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = 32'sd1;
    bus.mc_valid = 1'b1; bus.mc_addr = 5'd5; bus.mc_data = 32'sd645;
    step();
    bus.mc_valid = 1'b0;
    chk_rf("sq_fill", 1'b1, 9, 1);
    chk("sq_fill.count", 32'(bus.fifo_count), 1);
    bus.wb_addr = 5'd5; bus.wb_data = 32'sd12;
    step();
    chk_rf("sq_a", 1'b1, 5, 12);
    bus.wb_en = 1'b0;
    step();
    chk_rf("sq_pop", 1'b0, 5, 12);
    chk("sq_pop.count", 32'(bus.fifo_count), 0);

    // Incoming B pushed already squashed by a same-cycle A write
    bus.wb_en = 1'b1; bus.wb_addr = 5'd6; bus.wb_data = 32'sd77;
    bus.mc_valid = 1'b1; bus.mc_addr = 5'd6; bus.mc_data = 32'sd88;
    step();
    bus.mc_valid = 1'b0;
    chk_rf("sq_in_a", 1'b1, 6, 77);
    chk("sq_in.count", 32'(bus.fifo_count), 1);
    bus.wb_en = 1'b0;
    step();
    chk_rf("sq_in_pop", 1'b0, 6, 77);
    chk("sq_in_pop.count", 32'(bus.fifo_count), 0);

    // Reset mid-drain
    bus.wb_en = 1'b1; bus.wb_addr = 5'd10; bus.wb_data = 32'sd100;
    bus.mc_valid = 1'b1; bus.mc_addr = 5'd11; bus.mc_data = 32'sd111;
    step();
    bus.mc_addr = 5'd12; bus.mc_data = 32'sd122;
    step();
    bus.mc_valid = 1'b0;
    chk("pre_rst.count", 32'(bus.fifo_count), 2);
    RST = 1'b0;
    bus.wb_en = 1'b0;
    step();
    chk_rf("mid_rst", 1'b0, 0, 0);
    chk("mid_rst.count", 32'(bus.fifo_count), 0);
    chk("mid_rst.stall", 32'(bus.stall_req), 0);
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst.rf_we", 32'(bus.rf_we), 0);
      chk("post_rst.ready", 32'(bus.mc_ready), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the single register-file write port between two requesters:
  - Port A: the pipeline writeback stage (pipeline5 outputs). No backpressure; must never be delayed.
  - Port B: a multi-cycle unit result return (long MUL/DIV, memory return). Valid/ready handshake, buffered in a small FIFO.
- Pipeline writeback always wins the port.
- B results drain in idle slots. A starvation counter raises a stall request to the pipeline front end.
- Older buffered B results whose destination is overwritten by A are squashed (WAW protection).

Parameters:
- FIFO_DEPTH, 2, B-side buffer entries; power of 2, at least 2.
- PTR_WIDTH, 1, log2(FIFO_DEPTH).
- STARVE_LIMIT, 4, consecutive blocked cycles of a valid FIFO head before stall_req asserts.
- CNT_WIDTH, 3, starvation counter width; must hold STARVE_LIMIT.
- DATA_WIDTH, REG_ADDR_WIDTH: taken from params_proc.v.

Ports:
- clk_in  in  1  clock
- RST  in  1  synchronous, active-low reset
- wb_en  in  1  pipeline writeback enable (en_out of pipeline5)
- wb_addr  in  REG_ADDR_WIDTH  pipeline destination register
- wb_data  in  DATA_WIDTH  pipeline write data (signed)
- mc_valid  in  1  multi-cycle result valid
- mc_ready  out  1  arbiter can accept a B result
- mc_addr  in  REG_ADDR_WIDTH  B destination register
- mc_data  in  DATA_WIDTH  B write data (signed)
- rf_we  out  1  register-file write enable
- rf_addr  out  REG_ADDR_WIDTH  register-file write address
- rf_data  out  DATA_WIDTH  register-file write data
- stall_req  out  1  request pipeline to insert bubbles so B can drain
- fifo_count  out  PTR_WIDTH+1  occupied FIFO entries (debug/verification)

Behaviour:
- Reset (RST=0 at a clk_in edge):
  - rf_we=0, rf_addr=0, rf_data=0, stall_req=0.
  - FIFO emptied (count 0, all entry valid bits 0).
  - Starvation counter 0.
  - mc_ready=1 after the first clock with RST=1.
  - Reset mid-operation discards all buffered B entries; no write is issued for them.
- Handshake: mc_ready = !full, a registered-state function only (no combinational path from mc_valid or wb_en). A B transfer occurs when mc_valid && mc_ready. When full, mc_ready=0 even if a pop happens the same cycle.
- Output stage is registered: rf_* reflect the grant decision one cycle after the inputs (latency 1 for both A and B bypass).
- Grant priority per cycle:
  - 1) wb_en=1: write A.
  - 2) Else FIFO non-empty: pop head. If the head's valid bit is set, write it; if squashed, rf_we=0 that cycle.
  - 3) Else FIFO empty and B transfer: bypass B directly to the output with no push.
  - 4) Else rf_we=0; rf_addr/rf_data hold their previous values.
- Push: a B transfer is pushed when not bypassed. This includes the case where FIFO is empty but wb_en=1. Push and pop in the same cycle are legal; count is unchanged.
- Squash: when wb_en=1, every FIFO entry with addr == wb_addr clears its valid bit that cycle. An incoming B transfer in the same cycle with mc_addr == wb_addr is accepted and pushed already squashed. Pipeline writeback is always the architecturally newer value.
- Starvation counter:
  - Increments when FIFO non-empty && wb_en=1; saturates at STARVE_LIMIT.
  - Clears on any pop.
  - stall_req is registered: set when counter reaches STARVE_LIMIT, held until FIFO empty, cleared the cycle after the last pop.
  - The pipeline guarantees wb_en=0 within finite cycles of stall_req=1; the arbiter does not time out.
- Order: B results are written in acceptance order. A writes are never reordered or dropped.
- Wrap-around: pointers wrap modulo FIFO_DEPTH. count distinguishes full from empty.

Decomposition:
- params_proc.v (shared) supplies DATA_WIDTH, REG_ADDR_WIDTH, CTRL_WIDTH. Add the arbiter defaults (FIFO depth, starvation limit) there as named constants.
- Sub-module wb_fifo: DEPTH-entry circular buffer of {valid, addr, data}, with push/pop, count, full/empty, and squash-by-address input (squash_en, squash_addr).
- The top level holds the grant mux, the output register, and the starvation counter.

Test Plan:
- Reset then idle: RST=0 two cycles → rf_we=0, rf_addr=0, rf_data=0, stall_req=0, mc_ready=1, fifo_count=0.
- A only: wb_en=1, wb_addr=4, wb_data=1712 → next cycle rf_we=1, rf_addr=4, rf_data=1712. Then wb_en=0 → rf_we=0.
- B bypass: FIFO empty, wb_en=0, mc_valid=1, mc_addr=7, mc_data=956 → next cycle rf_we=1, rf_addr=7, rf_data=956; fifo_count stays 0.
- Contention and fill:
  - Hold wb_en=1 (addr 1, data 15) while sending B (addr 2, data 27) then B (addr 3, data 3562) → fifo_count=2, mc_ready=0.
  - After 4 blocked cycles stall_req=1.
  - Drop wb_en → writes 2/27 then 3/3562 on consecutive cycles; stall_req=0 the cycle after the second pop.
- Squash: FIFO holds addr 5 (data 645); then wb_en=1, wb_addr=5, wb_data=12 → rf writes 5/12. The later pop of the entry gives rf_we=0, and register 5 is never written with 645.
- Reset mid-drain: FIFO count 2, assert RST=0 one cycle → fifo_count=0, stall_req=0, no further B writes appear.
